// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 keypad scanner.
// Used by keypad_scanner and kp_debounce.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_MULTI
  } kp_state_t;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Index is 4*col+row.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'hE,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [3:0] key_code(input logic [15:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) c = KEY_MAP[i];
    return c;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Whole-matrix debouncer: a frame snapshot must repeat FRAMES times
// before it becomes the debounced matrix state.
module kp_debounce
  import keypad_pkg::*;
#(
  parameter int FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic [15:0] snap,
  output logic [15:0] deb,
  output logic        frame
);

  localparam int CW = $clog2(FRAMES + 1);

  logic [15:0]   cand;
  logic [CW-1:0] cnt;
  logic [15:0]   cand_nx;
  logic [CW-1:0] cnt_nx;

  always_comb begin
    cand_nx = cand;
    cnt_nx  = cnt;
    if (snap != cand) begin
      cand_nx = snap;
      cnt_nx  = CW'(1);
    end else if (cnt != CW'(FRAMES)) begin
      cnt_nx = cnt + CW'(1);
    end
  end

  // frame marks the cycle in which deb reflects the frame just closed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand  <= '0;
      cnt   <= '0;
      deb   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= strobe;
      if (strobe) begin
        cand <= cand_nx;
        cnt  <= cnt_nx;
        if (cnt_nx == CW'(FRAMES))
          deb <= cand_nx;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, row sync, debounce, key FSM, handshake.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_DWELL_CYC   = 50000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_keypad_row,
  output logic [3:0] o_keypad_col,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  input  logic       i_key_ack,
  output logic       o_key_pressed,
  output logic       o_overrun
);

  if (COL_DWELL_CYC < 4 || DEBOUNCE_FRAMES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("keypad_scanner: invalid parameter set");
  end

  localparam int DW = $clog2(COL_DWELL_CYC);

  logic          run;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [11:0]   acc;
  logic          last;
  logic          strobe;
  logic [15:0]   snap;
  logic [15:0]   deb;
  logic          frame;

  assign last   = run && (dwell == DW'(COL_DWELL_CYC - 1));
  assign strobe = last && (col == 2'd3);
  assign snap   = {~sync2, acc};

  // Scan and sample; column 3 feeds the snapshot directly at frame end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run          <= 1'b0;
      dwell        <= '0;
      col          <= '0;
      o_keypad_col <= COL_IDLE;
      sync1        <= 4'b1111;
      sync2        <= 4'b1111;
      acc          <= '0;
    end else begin
      sync1 <= i_keypad_row;
      sync2 <= sync1;
      if (!run) begin
        run          <= 1'b1;
        o_keypad_col <= col_drive(2'd0);
      end else if (last) begin
        dwell        <= '0;
        col          <= col + 2'd1;
        o_keypad_col <= col_drive(col + 2'd1);
        case (col)
          2'd0:    acc[3:0]  <= ~sync2;
          2'd1:    acc[7:4]  <= ~sync2;
          2'd2:    acc[11:8] <= ~sync2;
          default: ;
        endcase
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  kp_debounce #(
    .FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk   (i_clk),
    .rst   (i_rst),
    .strobe(strobe),
    .snap  (snap),
    .deb   (deb),
    .frame (frame)
  );

  kp_state_t   state;
  logic [15:0] held;
  logic        ev;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt;
  logic          rpt_first;
  logic          rpt_hit;

  assign rpt_hit = (rpt + RW'(1)) ==
                   (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD));
`endif

  always_comb begin
    ev = 1'b0;
    if (frame) begin
      if (state == S_IDLE)
        ev = is_onehot(deb);
`ifdef KEYPAD_REPEAT_EN
      else if (state == S_HELD)
        ev = (deb == held) && rpt_hit;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      held          <= '0;
      o_key_valid   <= 1'b0;
      o_key_code    <= '0;
      o_overrun     <= 1'b0;
      o_key_pressed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt           <= '0;
      rpt_first     <= 1'b1;
`endif
    end else begin
      o_key_pressed <= |deb;
      if (frame) begin
        unique case (state)
          S_IDLE: begin
            if (is_onehot(deb)) begin
              state <= S_HELD;
              held  <= deb;
            end else if (deb != '0) begin
              state <= S_MULTI;
            end
          end
          S_HELD: begin
            if (deb == '0)
              state <= S_IDLE;
            else if (deb != held)
              state <= S_MULTI;
          end
          S_MULTI: begin
            if (deb == '0)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
`ifdef KEYPAD_REPEAT_EN
      if (state != S_HELD || (frame && deb != held)) begin
        rpt       <= '0;
        rpt_first <= 1'b1;
      end else if (frame) begin
        if (rpt_hit) begin
          rpt       <= '0;
          rpt_first <= 1'b0;
        end else begin
          rpt <= rpt + RW'(1);
        end
      end
`endif
      // An ack in the same cycle as a new event frees the slot for it.
      if (ev) begin
        if (!o_key_valid) begin
          o_key_valid <= 1'b1;
          o_key_code  <= key_code(deb);
        end else if (i_key_ack) begin
          o_key_code <= key_code(deb);
          o_overrun  <= 1'b0;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_key_valid && i_key_ack) begin
        o_key_valid <= 1'b0;
        o_overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a frame-level reference model.
// Honours KEYPAD_REPEAT_EN when building the expected event list.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int DWELL = 4;
  localparam int DEB   = 2;
  localparam int RDLY  = 3;
  localparam int RPER  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic       valid;
  logic [3:0] code;
  logic       ack;
  logic       pressed;
  logic       ovr;
  logic       ack_auto = 1'b0;
  logic       ack_man  = 1'b0;
  logic       auto_ack = 1'b1;
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int cyc;

  assign ack = auto_ack ? ack_auto : ack_man;

  always #5 clk = ~clk;

  keypad_scanner #(
    .COL_DWELL_CYC  (DWELL),
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_keypad_row (row),
    .o_keypad_col (col),
    .o_key_valid  (valid),
    .o_key_code   (code),
    .i_key_ack    (ack),
    .o_key_pressed(pressed),
    .o_overrun    (ovr)
  );

  // Matrix: a closed key pulls its row low when its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[4*c+r] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Keypad face, row-major as printed on the part.
  logic [3:0] layout [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  int          exp_code [$];
  int          exp_cyc  [$];
  logic [15:0] m_cand, m_deb, m_held;
  int          m_cnt, m_st, m_rpt;
  bit          m_first, m_pend, m_ovr, p1, p2;
  logic [3:0]  m_code;

  task automatic model_reset();
    m_cand = '0; m_deb = '0; m_held = '0;
    m_cnt = 0; m_st = 0; m_rpt = 0;
    m_first = 1; m_pend = 0; m_ovr = 0;
    p1 = 0; p2 = 0; m_code = '0;
  endtask

  task automatic emit(input int k);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (m_deb[i]) idx = i;
    if (m_pend && !auto_ack) begin
      m_ovr = 1;
    end else begin
      m_code = layout[idx % 4][idx / 4];
      exp_code.push_back(int'(m_code));
      exp_cyc.push_back(18 + 16 * k);
      if (!auto_ack) m_pend = 1;
    end
  endtask

  // m_st: 0 idle, 1 one key held, 2 chord/roll-over
  task automatic model_frame(input logic [15:0] m, input int k);
    if (m == m_cand) begin
      if (m_cnt < DEB) m_cnt++;
    end else begin
      m_cand = m;
      m_cnt  = 1;
    end
    if (m_cnt == DEB) m_deb = m_cand;
    p2 = p1;
    p1 = (m_deb != 0);
    case (m_st)
      0: if (m_deb != 0) begin
           if ($countones(m_deb) == 1) begin
             emit(k);
             m_st = 1; m_held = m_deb; m_rpt = 0; m_first = 1;
           end else m_st = 2;
         end
      1: if (m_deb == 0) m_st = 0;
         else if (m_deb != m_held) m_st = 2;
         else begin
`ifdef KEYPAD_REPEAT_EN
           m_rpt++;
           if (m_rpt == (m_first ? RDLY : RPER)) begin
             emit(k);
             m_rpt = 0; m_first = 0;
           end
`endif
         end
      default: if (m_deb == 0) m_st = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic frame(input logic [15:0] m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 16) != 1 && n < 64);
    if ((cyc % 16) != 1) begin
      checks++; errors++;
      $display("FAIL frame_align: cyc %0d", cyc);
    end
    check("pressed", 32'(pressed), 32'(p2));
    keys = m;
    model_frame(m, (cyc - 1) / 16);
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) frame(m);
  endtask

  bit pv = 0;

  // Monitor: every rising o_key_valid must match the head of the queue.
  initial begin
    int ec, ecy;
    forever begin
      @(negedge clk);
      ack_auto = 1'b0;
      if (rst) begin
        pv = 0;
      end else begin
        if (valid && !pv) begin
          checks++;
          if (exp_code.size() == 0) begin
            errors++;
            $display("FAIL event: got code %h at cyc %0d want no event",
                     code, cyc);
          end else begin
            ec  = exp_code.pop_front();
            ecy = exp_cyc.pop_front();
            if (int'(code) != ec || cyc != ecy) begin
              errors++;
              $display("FAIL event: got code %h cyc %0d want code %h cyc %0d",
                       code, cyc, ec[3:0], ecy);
            end
          end
          if (auto_ack) ack_auto = 1'b1;
        end else if (exp_cyc.size() > 0 && cyc > exp_cyc[0] + 2) begin
          checks++; errors++;
          ec  = exp_code.pop_front();
          ecy = exp_cyc.pop_front();
          $display("FAIL event_missing: got none want code %h cyc %0d",
                   ec[3:0], ecy);
        end
        pv = valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] rm;
  int          sel;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0000_000F);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_code", 32'(code), 32'h0);
    check("rst_pressed", 32'(pressed), 32'h0);
    check("rst_overrun", 32'(ovr), 32'h0);
    rst = 1'b0;

    frames(16'h0040, 6);
    frames(16'h0000, 4);

    frames(16'h0001, 1);
    frames(16'h0000, 4);
    check("bounce_valid", 32'(valid), 32'h0);

    frames(16'h0021, 5);
    check("chord_pressed", 32'(pressed), 32'h1);
    check("chord_valid", 32'(valid), 32'h0);
    check("chord_state", 32'(dut.state), 32'(keypad_pkg::S_MULTI));
    frames(16'h0000, 4);

    auto_ack = 1'b0;
    frames(16'h0100, 3);
    frames(16'h0000, 3);
    frames(16'h1000, 3);
    frames(16'h0000, 3);
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_code", 32'(code), 32'(m_code));
    check("ovr_flag", 32'(ovr), 32'(m_ovr));
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    m_pend = 0; m_ovr = 0;
    check("ack_valid", 32'(valid), 32'h0);
    check("ack_overrun", 32'(ovr), 32'h0);

    frames(16'h0080, 4);
    check("pre_rst_valid", 32'(valid), 32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_col", 32'(col), 32'h0000_000F);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_code", 32'(code), 32'h0);
    check("mid_rst_pressed", 32'(pressed), 32'h0);
    check("mid_rst_overrun", 32'(ovr), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    auto_ack = 1'b1;
    rst = 1'b0;
    frames(16'h0080, 5);
    frames(16'h0000, 3);

    frames(16'h8000, 12);
    frames(16'h0000, 4);

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 3));
      rm  = '0;
      if (sel == 1 || sel == 2) rm[$urandom_range(0, 15)] = 1'b1;
      if (sel == 2) rm[$urandom_range(0, 15)] = 1'b1;
      frames(rm, int'($urandom_range(1, 4)));
    end
    frames(16'h0000, 4);

    check("queue_empty", 32'(exp_code.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
